// File: rtl/branch_predict_unit.sv
// Branch predictor: bimodal table of 2-bit counters plus execute-stage resolution and fetch redirect.
// Optional BPU_STATS_EN adds saturating branch / redirect counters.
module branch_predict_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_fetch_pc,
   output logic            o_pred_taken,
   input  logic            i_ex_valid,
   input  logic [XLEN-1:0] i_ex_pc,
   input  logic [6:0]      i_ex_opcode,
   input  logic [2:0]      i_ex_funct3,
   input  logic [XLEN-1:0] i_ex_rs1,
   input  logic [XLEN-1:0] i_ex_rs2,
   input  logic            i_ex_pred_taken,
   input  logic [XLEN-1:0] i_ex_target,
   input  logic [XLEN-1:0] i_ex_alu_result,
`ifdef BPU_STATS_EN
   output logic [31:0]     o_stat_branches,
   output logic [31:0]     o_stat_mispredicts,
`endif
   output logic            o_redirect,
   output logic [XLEN-1:0] o_redirect_pc
);

   localparam int IW = $clog2(BHT_ENTRIES);
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [1:0]      r_bht [BHT_ENTRIES];
   logic            r_redirect;
   logic [XLEN-1:0] r_redirect_pc;

   logic [IW-1:0]   w_idx_f, w_idx_ex;
   logic            w_res, w_b_legal, w_is_jalr, w_taken, w_mis, w_redir_nxt;
   logic [XLEN-1:0] w_redir_pc_nxt;
   logic            w_unused;

   assign w_idx_f      = i_fetch_pc[IW+1:2];
   assign w_idx_ex     = i_ex_pc[IW+1:2];
   assign o_pred_taken = r_bht[w_idx_f][1];
   assign w_unused     = ^{i_fetch_pc[XLEN-1:IW+2], i_fetch_pc[1:0], i_ex_alu_result[0]};

   // Instructions arriving while a redirect is out are wrong-path and ignored.
   assign w_res     = i_ex_valid && !r_redirect;
   assign w_b_legal = w_res && (i_ex_opcode == OP_BRANCH) &&
                      (i_ex_funct3 != 3'b010) && (i_ex_funct3 != 3'b011);
   assign w_is_jalr = w_res && (i_ex_opcode == OP_JALR);

   always_comb begin
      w_taken = 1'b0;
      case (i_ex_funct3)
         3'b000:  w_taken = (i_ex_rs1 == i_ex_rs2);
         3'b001:  w_taken = (i_ex_rs1 != i_ex_rs2);
         3'b100:  w_taken = ($signed(i_ex_rs1) <  $signed(i_ex_rs2));
         3'b101:  w_taken = ($signed(i_ex_rs1) >= $signed(i_ex_rs2));
         3'b110:  w_taken = (i_ex_rs1 <  i_ex_rs2);
         3'b111:  w_taken = (i_ex_rs1 >= i_ex_rs2);
         default: w_taken = 1'b0;
      endcase
   end

   assign w_mis       = w_b_legal && (w_taken != i_ex_pred_taken);
   assign w_redir_nxt = w_mis || w_is_jalr;

   always_comb begin
      w_redir_pc_nxt = i_ex_pc + XLEN'(4);
      if (w_is_jalr)
         w_redir_pc_nxt = {i_ex_alu_result[XLEN-1:1], 1'b0};
      else if (w_taken)
         w_redir_pc_nxt = i_ex_target;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
      end else begin
         r_redirect <= w_redir_nxt;
         if (w_redir_nxt) r_redirect_pc <= w_redir_pc_nxt;
         if (w_b_legal) begin
            if (w_taken) begin
               if (r_bht[w_idx_ex] != 2'b11) r_bht[w_idx_ex] <= r_bht[w_idx_ex] + 2'd1;
            end else begin
               if (r_bht[w_idx_ex] != 2'b00) r_bht[w_idx_ex] <= r_bht[w_idx_ex] - 2'd1;
            end
         end
      end
   end

   assign o_redirect    = r_redirect;
   assign o_redirect_pc = r_redirect_pc;

`ifdef BPU_STATS_EN
   logic [31:0] r_stat_br, r_stat_mis;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stat_br  <= '0;
         r_stat_mis <= '0;
      end else begin
         if (w_b_legal && (r_stat_br != '1))    r_stat_br  <= r_stat_br + 32'd1;
         if (w_redir_nxt && (r_stat_mis != '1)) r_stat_mis <= r_stat_mis + 32'd1;
      end
   end

   assign o_stat_branches    = r_stat_br;
   assign o_stat_mispredicts = r_stat_mis;
`endif

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data/PC width.
REQ-002 Parameter BHT_ENTRIES, default 64, SHALL set branch history table depth; legal values are powers of two, 4..1024; IW = log2(BHT_ENTRIES).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 fetch_pc  in  XLEN  fetch-stage PC for lookup.
REQ-006 pred_taken  out  1  prediction for fetch_pc.
REQ-007 ex_valid  in  1  execute-stage instruction valid.
REQ-008 ex_pc  in  XLEN  PC of execute instruction.
REQ-009 ex_opcode  in  7  opcode; ex_funct3  in  3  funct3.
REQ-010 ex_rs1, ex_rs2  in  XLEN each  compare operands.
REQ-011 ex_pred_taken  in  1  prediction carried with instruction.
REQ-012 ex_target  in  XLEN  PC+imm; ex_alu_result  in  XLEN  JALR sum.
REQ-013 redirect  out  1  one-cycle fetch redirect/flush pulse.
REQ-014 redirect_pc  out  XLEN  redirect target, valid when redirect=1.

Function
REQ-015 Index SHALL be pc[IW+1:2]; each BHT entry a 2-bit saturating counter.
REQ-016 pred_taken SHALL equal MSB of bht[index(fetch_pc)], combinational, same cycle.
REQ-017 Resolution: evaluated only when ex_valid=1 and redirect=0 (instruction in the cycle of an asserted redirect is wrong-path and SHALL be ignored completely).
REQ-018 B-type (1100011) actual-taken: 000 rs1==rs2; 001 !=; 100 signed <; 101 signed >=; 110 unsigned <; 111 unsigned >=; 010/011 never taken, no BHT update, no redirect.
REQ-019 B-type mispredict (actual != ex_pred_taken) SHALL register redirect=1 next cycle with redirect_pc = ex_target if actual taken, else ex_pc+4 (mod 2^XLEN).
REQ-020 JALR (1100111) SHALL always register redirect=1 next cycle, redirect_pc = ex_alu_result with bit0 cleared.
REQ-021 JAL (1101111) and all other opcodes SHALL cause no redirect and no BHT update.
REQ-022 Valid B-type (legal funct3) SHALL update bht[index(ex_pc)] at the same edge: taken -> +1 saturating at 3; not-taken -> -1 saturating at 0.
REQ-023 Redirect latency SHALL be exactly 1 cycle; redirect SHALL be high for exactly 1 cycle per event and low otherwise.
REQ-024 Same-entry read/write in one cycle: pred_taken SHALL reflect the pre-update value (no bypass).
REQ-025 Aliasing PCs sharing an index SHALL share one counter; no tag check.

Reset
REQ-026 rst=1 SHALL set every BHT entry to 2'b01 (weakly not-taken) at the next edge.
REQ-027 rst=1 SHALL force redirect=0, redirect_pc=0; a redirect pending from the reset cycle SHALL be dropped.
REQ-028 While rst=1, ex_valid SHALL be ignored; pred_taken reflects reset contents from the first cycle after reset.

Configuration
REQ-029 Macro BPU_STATS_EN defined: add outputs stat_branches and stat_mispredicts (32 bits each), counting resolved legal B-types and redirects (B-type mispredict + JALR) respectively, saturating at 0xFFFFFFFF, cleared by rst.
REQ-030 BPU_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 After reset, fetch_pc=0x100 -> pred_taken=0; BEQ at 0x100, rs1=rs2=5, ex_pred_taken=0, ex_target=0x140 -> next cycle redirect=1, redirect_pc=0x140; then pred_taken at 0x100 = 1.
REQ-032 BLT rs1=0xFFFFFFFF, rs2=1, pred=1 -> no redirect; BLTU same operands, pred=1 -> redirect_pc=ex_pc+4.
REQ-033 JALR ex_alu_result=0x2003 -> redirect_pc=0x2002; ex_valid B-type mispredict in the following cycle (redirect high) -> no redirect, no BHT change.
REQ-034 Four taken BNEs at 0x200 -> counter saturates at 3; two not-taken -> value 1, pred_taken=0; PC 0x300 (alias with BHT_ENTRIES=64) reads same counter.
REQ-035 Mispredict then rst asserted same cycle -> redirect stays 0; all entries return to 01; with BPU_STATS_EN, stats read 0.
REQ-036 Sweep BHT_ENTRIES=4 and 1024, XLEN=64; ex_pc=0xFFFFFFFFFFFFFFFC not-taken mispredict -> redirect_pc=0.
